// File: rtl/mips_defs.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states,
// ALU operations, PC source and register destination selects.
package mips_defs;

  typedef enum logic [3:0] {
    StIf     = 4'b0000,
    StId     = 4'b0001,
    StExeMem = 4'b0010,
    StMem    = 4'b0011,
    StWbLd   = 4'b0100,
    StExeBr  = 4'b0101,
    StExeAl  = 4'b0110,
    StWbAl   = 4'b0111,
    StHalt   = 4'b1000
  } state_e;

  localparam logic [5:0] OpAdd  = 6'b000000;
  localparam logic [5:0] OpSub  = 6'b000001;
  localparam logic [5:0] OpAddi = 6'b000010;
  localparam logic [5:0] OpOr   = 6'b010000;
  localparam logic [5:0] OpAnd  = 6'b010001;
  localparam logic [5:0] OpOri  = 6'b010010;
  localparam logic [5:0] OpSll  = 6'b011000;
  localparam logic [5:0] OpSlt  = 6'b100110;
  localparam logic [5:0] OpSlti = 6'b100111;
  localparam logic [5:0] OpSw   = 6'b110000;
  localparam logic [5:0] OpLw   = 6'b110001;
  localparam logic [5:0] OpBeq  = 6'b110100;
  localparam logic [5:0] OpBne  = 6'b110101;
  localparam logic [5:0] OpBltz = 6'b110110;
  localparam logic [5:0] OpJ    = 6'b111000;
  localparam logic [5:0] OpJr   = 6'b111001;
  localparam logic [5:0] OpJal  = 6'b111010;
  localparam logic [5:0] OpHalt = 6'b111111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluOr  = 3'b010;
  localparam logic [2:0] AluAnd = 3'b011;
  localparam logic [2:0] AluSll = 3'b100;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [1:0] PcNext   = 2'b00;
  localparam logic [1:0] PcBranch = 2'b01;
  localparam logic [1:0] PcReg    = 2'b10;
  localparam logic [1:0] PcJump   = 2'b11;

  localparam logic [1:0] DstRt = 2'b00;
  localparam logic [1:0] DstRd = 2'b01;
  localparam logic [1:0] DstRa = 2'b10;

  // Register-to-register and immediate arithmetic that goes through EXE_AL/WB_AL.
  function automatic logic is_alu_op(input logic [5:0] op);
    return op inside {OpAdd, OpSub, OpAddi, OpOr, OpAnd, OpOri, OpSll, OpSlt, OpSlti};
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational control-word decoder: maps the current FSM state, opcode and
// ALU flags to datapath enables and selects (PCWre is produced by the FSM).
module mc_decode
  import mips_defs::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       sign,
  output logic       IRWre,
  output logic       mRD,
  output logic       mWR,
  output logic       RegWre,
  output logic [1:0] PCSrc,
  output logic [1:0] RegDst,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic       DBDataSrc,
  output logic [2:0] ALUOp
);

  logic taken;

  always_comb begin
    taken = ((opcode == OpBeq) && zero) || ((opcode == OpBne) && !zero) ||
            ((opcode == OpBltz) && sign);

    IRWre  = (state == StIf);
    mRD    = (state == StMem) && (opcode == OpLw);
    mWR    = (state == StMem) && (opcode == OpSw);
    RegWre = (state == StWbAl) || (state == StWbLd) || ((state == StId) && (opcode == OpJal));

    PCSrc = PcNext;
    if ((state == StExeBr) && taken) begin
      PCSrc = PcBranch;
    end else if ((state == StId) && (opcode == OpJr)) begin
      PCSrc = PcReg;
    end else if ((state == StId) && ((opcode == OpJ) || (opcode == OpJal))) begin
      PCSrc = PcJump;
    end

    // Datapath selects depend only on the instruction; the enables gate their effect.
    RegDst = DstRt;
    if (opcode == OpJal) begin
      RegDst = DstRa;
    end else if (opcode inside {OpAdd, OpSub, OpOr, OpAnd, OpSll, OpSlt}) begin
      RegDst = DstRd;
    end

    ALUSrcA   = (opcode == OpSll);
    ALUSrcB   = opcode inside {OpAddi, OpOri, OpSlti, OpSw, OpLw};
    ExtSel    = (opcode != OpOri);
    DBDataSrc = (opcode == OpLw);

    ALUOp = AluAdd;
    if (opcode inside {OpSub, OpBeq, OpBne}) begin
      ALUOp = AluSub;
    end else if (opcode inside {OpOr, OpOri}) begin
      ALUOp = AluOr;
    end else if (opcode == OpAnd) begin
      ALUOp = AluAnd;
    end else if (opcode == OpSll) begin
      ALUOp = AluSll;
    end else if (opcode inside {OpSlt, OpSlti}) begin
      ALUOp = AluSlt;
    end
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control unit: instruction FSM, retired-instruction counter
// and the combinational control-word decoder.
module mc_control
  import mips_defs::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             sign,
  output logic             PCWre,
  output logic             IRWre,
  output logic             mRD,
  output logic             mWR,
  output logic             RegWre,
  output logic [1:0]       PCSrc,
  output logic [1:0]       RegDst,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic             ExtSel,
  output logic             DBDataSrc,
  output logic [2:0]       ALUOp,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             halted
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIf: state_d = StId;
      StId: begin
        if (opcode inside {OpJ, OpJr, OpJal}) begin
          state_d = StIf;
        end else if (opcode == OpHalt) begin
          state_d = StHalt;
        end else if (opcode inside {OpBeq, OpBne, OpBltz}) begin
          state_d = StExeBr;
        end else if (opcode inside {OpSw, OpLw}) begin
          state_d = StExeMem;
        end else if (is_alu_op(opcode)) begin
          state_d = StExeAl;
        end else begin
          state_d = StIf;  // illegal opcode retires as a NOP
        end
      end
      StExeAl:  state_d = StWbAl;
      StWbAl:   state_d = StIf;
      StExeBr:  state_d = StIf;
      StExeMem: state_d = StMem;
      StMem:    state_d = (opcode == OpLw) ? StWbLd : StIf;
      StWbLd:   state_d = StIf;
      StHalt:   state_d = StHalt;
      default:  state_d = StIf;
    endcase
  end

  // IF always advances to ID, so a next state of IF marks the final cycle.
  assign PCWre = (state_d == StIf);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIf;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (PCWre) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign halted  = (state_q == StHalt);

  mc_decode u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .zero      (zero),
    .sign      (sign),
    .IRWre     (IRWre),
    .mRD       (mRD),
    .mWR       (mWR),
    .RegWre    (RegWre),
    .PCSrc     (PCSrc),
    .RegDst    (RegDst),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ExtSel    (ExtSel),
    .DBDataSrc (DBDataSrc),
    .ALUOp     (ALUOp)
  );

endmodule
